// File: rtl/wimpfi_pkg.sv
// Shared types and constants for the WimpFi host-side frame parser.
package wimpfi_pkg;

    localparam int HDR_FIELD_W     = 8;
    localparam int FRAME_HDR_BYTES = 4;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_e;

    typedef enum logic [2:0] {
        P_DST  = 3'd0,
        P_SRC  = 3'd1,
        P_TYPE = 3'd2,
        P_LEN  = 3'd3,
        P_PAY  = 3'd4,
        P_DROP = 3'd5
    } parser_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wimpfi_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, registered byte strobe / framing error.
module wimpfi_uart_rx
    import wimpfi_pkg::*;
#(
    parameter int BIT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_framing_err
);

    localparam int HALF = BIT_CYC / 2;
    localparam int CW   = $clog2(BIT_CYC + 1);

    logic        meta_r, sync_r, prev_r;
    uart_state_e state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic [7:0]  byte_r;
    logic        strobe_r, ferr_r;

    // input synchronizer plus one-cycle history for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= rxd;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    // bit sampler state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= U_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            byte_r    <= 8'd0;
            strobe_r  <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            ferr_r   <= 1'b0;
            case (state_r)
                U_IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (prev_r && !sync_r) begin
                        state_r <= U_START;
                    end else begin
                        state_r <= U_IDLE;
                    end
                end
                U_START: begin
                    if (cnt_r == CW'(HALF - 1)) begin
                        cnt_r     <= {CW{1'b0}};
                        bit_idx_r <= 3'd0;
                        // a start bit that is high again at mid-bit was a glitch
                        state_r   <= sync_r ? U_IDLE : U_DATA;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                U_DATA: begin
                    if (cnt_r == CW'(BIT_CYC - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        shift_r <= {sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= U_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                U_STOP: begin
                    if (cnt_r == CW'(BIT_CYC - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= U_IDLE;
                        if (sync_r) begin
                            strobe_r <= 1'b1;
                            byte_r   <= shift_r;
                        end else begin
                            ferr_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= U_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign rx_byte        = byte_r;
    assign rx_strobe      = strobe_r;
    assign rx_framing_err = ferr_r;

endmodule

// File: rtl/wimpfi_host_frame_parser.sv
// WimpFi host deframer: UART RX, header/payload parser, payload FIFO with valid/ready.
// Optional inter-byte timeout enabled by defining WIMPFI_HOST_PARSER_TIMEOUT_EN.
module wimpfi_host_frame_parser
    import wimpfi_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rxd,
    output logic                   hdr_valid,
    output logic [HDR_FIELD_W-1:0] hdr_dst,
    output logic [HDR_FIELD_W-1:0] hdr_src,
    output logic [HDR_FIELD_W-1:0] hdr_type,
    output logic [HDR_FIELD_W-1:0] hdr_len,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [7:0]             frame_cnt,
    output logic [7:0]             err_cnt
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [7:0] rx_byte_s;
    logic       rx_strobe_s, rx_ferr_s;

    wimpfi_uart_rx #(.BIT_CYC(BIT_CYC)) u_uart_rx (
        .clk            (clk),
        .rst_n          (rst),
        .rxd            (uart_rxd),
        .rx_byte        (rx_byte_s),
        .rx_strobe      (rx_strobe_s),
        .rx_framing_err (rx_ferr_s)
    );

    parser_state_e          state_r;
    logic [HDR_FIELD_W-1:0] dst_buf_r, src_buf_r, type_buf_r;
    logic [HDR_FIELD_W-1:0] hdr_dst_r, hdr_src_r, hdr_type_r, hdr_len_r;
    logic [7:0]             remaining_r;
    logic                   hdr_valid_r, frame_done_r, frame_err_r, done_pend_r;
    logic [7:0]             frame_cnt_r, err_cnt_r;
    logic                   wr_req_r;
    logic [7:0]             wr_byte_r;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic             out_valid_r;
    logic             rd_fire_s, wr_fire_s, space_s, drop_s, timeout_s;

    // FIFO handshakes; space is judged at the strobe so the frame verdict can be issued with it
    always_comb begin
        rd_fire_s   = out_valid_r && out_ready;
        space_s     = (count_r != CNT_W'(FIFO_DEPTH)) || rd_fire_s;
        wr_fire_s   = wr_req_r && ((count_r != CNT_W'(FIFO_DEPTH)) || rd_fire_s);
        drop_s      = (state_r == P_DROP) || !space_s;
        count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, wr_fire_s}
                              - {{(CNT_W-1){1'b0}}, rd_fire_s};
    end

`ifdef WIMPFI_HOST_PARSER_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BYTES * 10 * BIT_CYC;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] to_cnt_r;

    // inter-byte idle counter, only armed while a frame is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (rx_strobe_s || (state_r == P_DST) || timeout_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    assign timeout_s = (state_r != P_DST) && (to_cnt_r == TO_W'(TO_LIMIT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // frame parser, pulses and saturating counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= P_DST;
            dst_buf_r    <= 8'd0;
            src_buf_r    <= 8'd0;
            type_buf_r   <= 8'd0;
            hdr_dst_r    <= 8'd0;
            hdr_src_r    <= 8'd0;
            hdr_type_r   <= 8'd0;
            hdr_len_r    <= 8'd0;
            remaining_r  <= 8'd0;
            hdr_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            done_pend_r  <= 1'b0;
            frame_cnt_r  <= 8'd0;
            err_cnt_r    <= 8'd0;
            wr_req_r     <= 1'b0;
            wr_byte_r    <= 8'd0;
        end else begin
            hdr_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            done_pend_r  <= 1'b0;
            wr_req_r     <= 1'b0;
            // zero-length frames report done one cycle after their header
            if (done_pend_r) begin
                frame_done_r <= 1'b1;
                frame_cnt_r  <= sat_inc8(frame_cnt_r);
            end else begin
                frame_done_r <= 1'b0;
            end
            if (rx_ferr_s || timeout_s) begin
                frame_err_r <= 1'b1;
                err_cnt_r   <= sat_inc8(err_cnt_r);
                state_r     <= P_DST;
            end else if (rx_strobe_s) begin
                case (state_r)
                    P_DST: begin
                        dst_buf_r <= rx_byte_s;
                        state_r   <= P_SRC;
                    end
                    P_SRC: begin
                        src_buf_r <= rx_byte_s;
                        state_r   <= P_TYPE;
                    end
                    P_TYPE: begin
                        type_buf_r <= rx_byte_s;
                        state_r    <= P_LEN;
                    end
                    P_LEN: begin
                        hdr_dst_r   <= dst_buf_r;
                        hdr_src_r   <= src_buf_r;
                        hdr_type_r  <= type_buf_r;
                        hdr_len_r   <= rx_byte_s;
                        hdr_valid_r <= 1'b1;
                        remaining_r <= rx_byte_s;
                        if (rx_byte_s == 8'd0) begin
                            done_pend_r <= 1'b1;
                            state_r     <= P_DST;
                        end else begin
                            state_r <= P_PAY;
                        end
                    end
                    P_PAY, P_DROP: begin
                        if (!drop_s) begin
                            wr_req_r  <= 1'b1;
                            wr_byte_r <= rx_byte_s;
                        end else begin
                            wr_req_r <= 1'b0;
                        end
                        if (remaining_r == 8'd1) begin
                            state_r <= P_DST;
                            if (drop_s) begin
                                frame_err_r <= 1'b1;
                                err_cnt_r   <= sat_inc8(err_cnt_r);
                            end else begin
                                frame_done_r <= 1'b1;
                                frame_cnt_r  <= sat_inc8(frame_cnt_r);
                            end
                        end else begin
                            remaining_r <= remaining_r - 8'd1;
                            state_r     <= drop_s ? P_DROP : P_PAY;
                        end
                    end
                    default: begin
                        state_r <= P_DST;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_ptr_r] <= wr_byte_r;
        end
    end

    assign out_data   = out_valid_r ? mem_r[rd_ptr_r] : 8'd0;
    assign out_valid  = out_valid_r;
    assign hdr_valid  = hdr_valid_r;
    assign hdr_dst    = hdr_dst_r;
    assign hdr_src    = hdr_src_r;
    assign hdr_type   = hdr_type_r;
    assign hdr_len    = hdr_len_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign frame_cnt  = frame_cnt_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_wimpfi_host_frame_parser.sv
// Directed bench for wimpfi_host_frame_parser at a reduced bit period (16 clocks per bit).
module tb_wimpfi_host_frame_parser;

    localparam int CLK_FREQ   = 160;
    localparam int BAUD_RATE  = 10;
    localparam int BIT_CYC    = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int TO_BYTES   = 4;
`ifdef WIMPFI_HOST_PARSER_TIMEOUT_EN
    localparam int TO_ON = 1;
`else
    localparam int TO_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       out_ready = 1'b1;
    logic       hdr_valid, out_valid, frame_done, frame_err;
    logic [7:0] hdr_dst, hdr_src, hdr_type, hdr_len, out_data, frame_cnt, err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hv_n = 0, fd_n = 0, fe_n = 0, ov_n = 0, t_hv = 0, t_fd = 0;
    logic [7:0] rxq[$];

    wimpfi_host_frame_parser #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_BYTES(TO_BYTES)
    ) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd),
        .hdr_valid(hdr_valid), .hdr_dst(hdr_dst), .hdr_src(hdr_src),
        .hdr_type(hdr_type), .hdr_len(hdr_len),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_done(frame_done), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (hdr_valid) begin hv_n++; t_hv = cyc; end
        if (frame_done) begin fd_n++; t_fd = cyc; end
        if (frame_err) fe_n++;
        if (out_valid) ov_n++;
        if (out_valid && out_ready) rxq.push_back(out_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        hv_n = 0; fd_n = 0; fe_n = 0; ov_n = 0;
        rxq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        uart_rxd = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_cyc(BIT_CYC);
        end
        uart_rxd = stop_ok;
        wait_cyc(BIT_CYC);
        uart_rxd = 1'b1;
    endtask

    task automatic send_hdr(input logic [7:0] d, input logic [7:0] s,
                            input logic [7:0] t, input logic [7:0] l);
        send_byte(d, 1'b1);
        send_byte(s, 1'b1);
        send_byte(t, 1'b1);
        send_byte(l, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        uart_rxd = 1'b1;
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(4);
    endtask

    initial begin
        // reset values
        wait_cyc(3);
        check_eq("rst_hdr_valid", {31'd0, hdr_valid}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_hdr_dst", {24'd0, hdr_dst}, 32'd0);
        check_eq("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b1;
        wait_cyc(4);

        // basic frame with 3 payload bytes
        clear_mon();
        send_hdr(8'h42, 8'h10, 8'h44, 8'h03);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        wait_cyc(3 * BIT_CYC);
        check_eq("f1_hv_count", hv_n, 32'd1);
        check_eq("f1_dst", {24'd0, hdr_dst}, 32'h42);
        check_eq("f1_src", {24'd0, hdr_src}, 32'h10);
        check_eq("f1_type", {24'd0, hdr_type}, 32'h44);
        check_eq("f1_len", {24'd0, hdr_len}, 32'd3);
        check_eq("f1_nbytes", rxq.size(), 32'd3);
        if (rxq.size() == 3) begin
            check_eq("f1_b0", {24'd0, rxq[0]}, 32'hAA);
            check_eq("f1_b1", {24'd0, rxq[1]}, 32'hBB);
            check_eq("f1_b2", {24'd0, rxq[2]}, 32'hCC);
        end
        check_eq("f1_done", fd_n, 32'd1);
        check_eq("f1_err", fe_n, 32'd0);
        check_eq("f1_frame_cnt", {24'd0, frame_cnt}, 32'd1);

        // zero-length frame
        clear_mon();
        send_hdr(8'hFF, 8'h01, 8'h30, 8'h00);
        wait_cyc(3 * BIT_CYC);
        check_eq("z_hv_count", hv_n, 32'd1);
        check_eq("z_dst", {24'd0, hdr_dst}, 32'hFF);
        check_eq("z_len", {24'd0, hdr_len}, 32'd0);
        check_eq("z_done", fd_n, 32'd1);
        check_eq("z_done_delay", t_fd - t_hv, 32'd1);
        check_eq("z_no_out_valid", ov_n, 32'd0);
        check_eq("z_frame_cnt", {24'd0, frame_cnt}, 32'd2);

        // framing error on third payload byte, then a good frame
        clear_mon();
        send_hdr(8'h01, 8'h02, 8'h03, 8'h05);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_cyc(2 * BIT_CYC);
        check_eq("fe_err", fe_n, 32'd1);
        check_eq("fe_err_cnt", {24'd0, err_cnt}, 32'd1);
        check_eq("fe_done", fd_n, 32'd0);
        send_hdr(8'h05, 8'h06, 8'h07, 8'h01);
        send_byte(8'h5A, 1'b1);
        wait_cyc(3 * BIT_CYC);
        check_eq("fe_next_dst", {24'd0, hdr_dst}, 32'h05);
        check_eq("fe_next_done", fd_n, 32'd1);
        check_eq("fe_nbytes", rxq.size(), 32'd3);
        if (rxq.size() == 3) check_eq("fe_next_byte", {24'd0, rxq[2]}, 32'h5A);
        check_eq("fe_frame_cnt", {24'd0, frame_cnt}, 32'd3);

        // FIFO overflow: LEN=20 with consumer stalled
        pulse_reset();
        @(posedge clk); #2 out_ready = 1'b0;
        clear_mon();
        send_hdr(8'h20, 8'h21, 8'h22, 8'd20);
        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b1);
        wait_cyc(3 * BIT_CYC);
        check_eq("ovf_err", fe_n, 32'd1);
        check_eq("ovf_done", fd_n, 32'd0);
        check_eq("ovf_err_cnt", {24'd0, err_cnt}, 32'd1);
        check_eq("ovf_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check_eq("ovf_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #2 out_ready = 1'b1;
        wait_cyc(FIFO_DEPTH + 8);
        check_eq("ovf_nbytes", rxq.size(), 32'd16);
        if (rxq.size() == 16) begin
            check_eq("ovf_first", {24'd0, rxq[0]}, 32'd0);
            check_eq("ovf_last", {24'd0, rxq[15]}, 32'd15);
        end

        // truncated frame: timeout build aborts after 4 idle byte times
        clear_mon();
        send_hdr(8'h30, 8'h31, 8'h32, 8'h05);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        wait_cyc(3 * 10 * BIT_CYC);
        check_eq("to_early", fe_n, 32'd0);
        wait_cyc(2 * 10 * BIT_CYC);
        check_eq("to_err", fe_n, TO_ON);
        check_eq("to_err_cnt", {24'd0, err_cnt}, 32'd1 + TO_ON);

        // reset in the middle of payload
        pulse_reset();
        clear_mon();
        send_hdr(8'h40, 8'h41, 8'h42, 8'h04);
        send_byte(8'h99, 1'b1);
        @(negedge clk);
        uart_rxd = 1'b0;
        wait_cyc(4 * BIT_CYC);
        rst = 1'b0;
        uart_rxd = 1'b1;
        wait_cyc(2);
        check_eq("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mr_hdr_dst", {24'd0, hdr_dst}, 32'd0);
        check_eq("mr_hdr_len", {24'd0, hdr_len}, 32'd0);
        check_eq("mr_err_cnt", {24'd0, err_cnt}, 32'd0);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check_eq("mr_no_pulses", fd_n + fe_n, 32'd0);
        clear_mon();
        send_hdr(8'h50, 8'h51, 8'h52, 8'h02);
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        wait_cyc(3 * BIT_CYC);
        check_eq("mr_next_dst", {24'd0, hdr_dst}, 32'h50);
        check_eq("mr_next_done", fd_n, 32'd1);
        check_eq("mr_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        check_eq("mr_nbytes", rxq.size(), 32'd2);
        if (rxq.size() == 2) check_eq("mr_b1", {24'd0, rxq[1]}, 32'hC2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wimpfi_host_frame_parser.md
# wimpfi_host_frame_parser

Host-side deframer downstream of the WimpFi network interface: consumes the asynchronous serial stream the receiver half drives toward the host (`a_txd`) and turns it back into parsed frames. Contains a mid-bit-sampling UART receiver, a header/payload parser FSM and a payload FIFO with valid/ready output. Used on the verification board and in the system bench as the frame sink and error monitor for received WimpFi traffic.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz
- BAUD_RATE, 9600: host serial rate; bit period BIT_CYC = CLK_FREQ/BAUD_RATE cycles (integer division)
- FIFO_DEPTH, 16: payload FIFO entries, power of two, ≥ 4
- TIMEOUT_BYTES, 4: inter-byte timeout mid-frame, in byte times (10·BIT_CYC each)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- uart_rxd  in  1  serial stream from the receiver's `a_txd`; idle high, 8N1, LSB first
- hdr_valid  out  1  one-cycle pulse: header fields valid
- hdr_dst, hdr_src, hdr_type, hdr_len  out  8 each  header fields, held until next header
- out_data  out  8  payload byte at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- frame_done  out  1  one-cycle pulse: frame ended cleanly
- frame_err  out  1  one-cycle pulse: frame aborted
- frame_cnt  out  8  good frames, saturates at 255
- err_cnt  out  8  aborted frames, saturates at 255

## Operation
- Stream format per frame: DST, SRC, TYPE, LEN, then LEN payload bytes (LEN = 0 legal).
- Input: two-flop synchronizer on uart_rxd; all logic uses the synchronized value.
- UART RX states: IDLE → START on falling edge; at BIT_CYC/2 re-sample, low → DATA, high → IDLE (glitch, no error). DATA samples 8 bits every BIT_CYC; STOP samples at BIT_CYC; high → byte strobe, low → framing error; both return to IDLE.
- Parser FSM: P_DST, P_SRC, P_TYPE, P_LEN, P_PAY, each advancing on byte strobe. P_LEN: load hdr_* registers, pulse hdr_valid; LEN = 0 → frame_done, back to P_DST; else → P_PAY with remaining = LEN. P_PAY: write byte to FIFO, decrement; at 0 → frame_done, P_DST.
- Abort (frame_err pulse, err_cnt++, back to P_DST): framing error in any parser state other than P_DST-awaiting-first-byte; FIFO full on payload write (byte dropped, remaining payload bytes still consumed in a drain state P_DROP, error issued at frame end instead of immediately); timeout (see Configuration).
- Framing error while in P_DST with no frame started: byte discarded, err_cnt++, frame_err pulses.
- Payload already in FIFO from an aborted frame stays; consumer uses frame_err to discard.
- Counters saturate; never wrap.
- FIFO simultaneous write and read when full: read frees slot, write accepted (no drop).

## Timing
- Reset values: hdr_valid, frame_done, frame_err, out_valid = 0; hdr_* = 0; out_data = 0; frame_cnt = err_cnt = 0; UART in IDLE, parser in P_DST, FIFO empty; synchronizer flops = 1.
- Byte strobe at stop-bit mid-sample cycle + 1.
- hdr_valid / frame_done / frame_err registered: cycle after triggering strobe.
- Payload byte: FIFO write cycle after strobe; out_valid high the following cycle (2 cycles after strobe).
- Counters update in the same cycle as their pulse.
- Reset mid-frame: immediate return to reset values, partial frame lost, no pulses.

## Configuration
- WIMPFI_HOST_PARSER_TIMEOUT_EN defined: counter runs whenever parser not in P_DST-idle; cleared on each byte strobe; reaching TIMEOUT_BYTES·10·BIT_CYC aborts the frame (frame_err, err_cnt++).
- Undefined: no timeout logic; a truncated frame stalls the parser until more bytes arrive or reset.

## Structure
- Shared package wimpfi_pkg: parser state enum, UART state enum, header field width constant (8), FRAME_HDR_BYTES = 4.
- One sub-module: wimpfi_uart_rx (synchronizer + bit sampler, outputs byte, strobe, framing_err). FIFO inline.

## Test plan
- Frame 0x42,0x10,0x44,0x03,0xAA,0xBB,0xCC at 9600 baud, out_ready=1 -> hdr_valid once with dst 0x42 src 0x10 type 0x44 len 3; out_data AA,BB,CC; frame_done once; frame_cnt=1.
- LEN=0 frame 0xFF,0x01,0x30,0x00 -> hdr_valid then frame_done next cycle, no out_valid.
- Stop bit forced low on third payload byte -> frame_err, err_cnt=1, parser accepts next frame correctly.
- out_ready=0, LEN=20 with FIFO_DEPTH=16 -> 16 bytes buffered, frame_err at frame end, err_cnt=1, frame_cnt=0.
- Timeout build: send header with LEN=5, then 2 bytes, go idle -> frame_err after 4 byte times; non-timeout build: no pulse.
- Assert rst=0 mid-payload -> all outputs to reset values; subsequent full frame parsed normally.
